nv_nvdla_cvif_rd_wrr_arb: RTL and testbench
===========================================

// Module: nv_nvdla_cvif_rd_wrr_arb
// PURPOSE
//  Weighted round-robin read arbiter for the CVIF read path: shares one read request channel among NREQ clients
//  (bdma, sdp, pdp, cdp, sdp_b, sdp_n, sdp_e, cdma_dat, cdma_wt, rbk, rsv_1, rsv_0, in index order 0..11).
//  Per-client weights and the outstanding-read limit come from the CVIF CSB register block (rd_weight_*, rd_os_cnt).
//  Drives the idle status bit back to that register block.
// PARAMETERS
//  NREQ   12  number of read clients
//  WW     8   weight / credit width
//  OSW    8   outstanding-count width
// PORTS
//  nvdla_core_clk    in   1        core clock
//  nvdla_core_rstn   in   1        reset: asynchronous, active-low; nvdla_core_rstn on clock nvdla_core_clk
//  req_valid         in   NREQ     per-client read request pending
//  req_ready         out  NREQ     one-hot grant strobe; request consumed this cycle
//  rd_weight         in   NREQ*WW  packed weights, client i at [i*WW +: WW]
//  rd_os_cnt         in   OSW      maximum reads in flight
//  arb_valid         out  1        granted request presented downstream
//  arb_id            out  4        client index of presented request
//  arb_ready         in   1        downstream accepts arb_valid/arb_id
//  rsp_done          in   1        one read completed (its last response beat returned)
//  os_inflight       out  OSW      reads accepted downstream and not yet completed
//  idle              out  1        1 when no req_valid, arb_valid==0 and os_inflight==0
// BEHAVIOUR
//  Reset: req_ready=0, arb_valid=0, arb_id=0, os_inflight=0, credits=0, rr pointer=0, idle=1.
//  Eligible client i: req_valid[i] && weight_i!=0 && credit_i!=0. A weight of 0 permanently masks the client.
//  Grant cycle condition: output slot free (!arb_valid || arb_ready) && (os_inflight + arb_valid) < rd_os_cnt
//    && at least one client is eligible.
//  Winner selection: first eligible client at or after the rr pointer, wrapping from NREQ-1 to 0.
//  On grant:
//   - req_ready[winner]=1 for exactly that cycle (combinational from the registered state).
//   - arb_valid/arb_id are registered: latency is 1 cycle from grant to arb_valid.
//   - credit_winner decrements by 1.
//   - rr pointer := winner+1 (mod NREQ) only when credit_winner reaches 0; otherwise the pointer holds,
//     so a client is granted up to weight consecutive times.
//  Reload: when no client is eligible but some client has req_valid && weight!=0, all credits load from
//    rd_weight in that cycle and no grant is issued; grants resume on the next cycle.
//  arb_valid/arb_id hold stable until arb_ready; a handshake with a simultaneous new grant is back-to-back
//    with no bubble.
//  os_inflight: +1 on arb_valid&&arb_ready, -1 on rsp_done; both in the same cycle leaves it unchanged.
//    rsp_done with os_inflight==0 is ignored (count stays 0). Increment never exceeds rd_os_cnt.
//  rd_os_cnt lowered below os_inflight: in-flight reads drain and no grant is issued until os_inflight < rd_os_cnt.
//    rd_os_cnt==0 blocks all grants.
//  Weight changes take effect at the next reload; current credits are not truncated.
//  A reset in mid-operation drops arb_valid immediately. In-flight reads are discarded from the count.
// CONFIGURATION
//  NVDLA_CVIF_ARB_PERF_EN defined:
//   - adds output perf_os_stall[31:0], a saturating count of cycles where some eligible client existed but the
//     grant was blocked only by the outstanding limit. Reset value 0.
//   - adds input perf_clr, which zeroes the count (perf_clr has priority over increment).
//  Macro not defined: neither port nor the counter exists, and arbitration behaviour is identical.
// STRUCTURE
//  Package nv_nvdla_cvif_arb_pkg: NREQ, WW, OSW, client-index localparams (CLI_BDMA=0 .. CLI_RSV_0=11).
//  Sub-module nv_nvdla_cvif_rr_pick: rotating-priority one-hot picker (eligible vector + pointer -> one-hot + index).
//  Top level holds the credits, pointer, output register, outstanding counter and optional perf counter.
// TESTING
//  1. Reset, all weights 1, rd_os_cnt=0xff, all 12 req_valid held, arb_ready=1, rsp_done tied to handshake.
//     Expect grants 0,1,2..11,0 one per cycle, except one reload cycle per round.
//  2. Weights bdma=3, sdp=1, others 0; both requesting.
//     Expect the pattern 0,0,0,1 repeating (reload gap allowed); no other id is ever seen.
//  3. rd_os_cnt=2, rsp_done never asserted.
//     Expect exactly 2 handshakes, then arb_valid=0 and os_inflight=2. One rsp_done gives one more grant.
//  4. arb_ready=0 for 5 cycles with arb_valid=1.
//     Expect arb_id stable, no req_ready pulses; on arb_ready=1, the next grant lands the following cycle.
//  5. Same cycle: handshake and rsp_done with os_inflight=1. Expect os_inflight stays 1.
//     Separately: rsp_done at 0 -> stays 0.
//  6. Assert nvdla_core_rstn low mid-burst. Expect arb_valid=0, os_inflight=0, idle=1 asynchronously.
//     With NVDLA_CVIF_ARB_PERF_EN and rd_os_cnt=0 for 10 cycles while requesting, expect perf_os_stall=10.

Source files
------------

// File: rtl/nv_nvdla_cvif_arb_pkg.sv
// Shared sizing, client indices and pointer helper for the CVIF read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nv_nvdla_cvif_arb_pkg;

  localparam int NREQ = 12;
  localparam int WW   = 8;
  localparam int OSW  = 8;
  localparam int IDW  = 4;

  localparam int CLI_BDMA     = 0;
  localparam int CLI_SDP      = 1;
  localparam int CLI_PDP      = 2;
  localparam int CLI_CDP      = 3;
  localparam int CLI_SDP_B    = 4;
  localparam int CLI_SDP_N    = 5;
  localparam int CLI_SDP_E    = 6;
  localparam int CLI_CDMA_DAT = 7;
  localparam int CLI_CDMA_WT  = 8;
  localparam int CLI_RBK      = 9;
  localparam int CLI_RSV_1    = 10;
  localparam int CLI_RSV_0    = 11;

  // Client index following i, wrapping from the last client back to 0.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/nv_nvdla_cvif_rr_pick.sv
// Rotating-priority picker: first set bit of elig at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module nv_nvdla_cvif_rr_pick
  import nv_nvdla_cvif_arb_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  // Scan clients starting at the pointer; the first eligible one wins.
  always_comb begin
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && elig[j]) begin
        gnt_any    = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cvif_rd_wrr_arb.sv
// Weighted round-robin CVIF read arbiter; optional stall counter under NVDLA_CVIF_ARB_PERF_EN.
// Latency: 1 cycle from grant (req_ready pulse) to arb_valid/arb_id.
// Backpressure: arb_valid/arb_id hold until arb_ready; grants also stop at the rd_os_cnt limit.
module nv_nvdla_cvif_rd_wrr_arb
  import nv_nvdla_cvif_arb_pkg::*;
(
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WW-1:0]   rd_weight,
  input  logic [OSW-1:0]       rd_os_cnt,
  output logic                 arb_valid,
  output logic [IDW-1:0]       arb_id,
  input  logic                 arb_ready,
  input  logic                 rsp_done,
  output logic [OSW-1:0]       os_inflight,
  output logic                 idle
`ifdef NVDLA_CVIF_ARB_PERF_EN
  ,
  input  logic                 perf_clr,
  output logic [31:0]          perf_os_stall
`endif
);

  logic [WW-1:0]   credit_q [NREQ];
  logic [WW-1:0]   credit_d [NREQ];
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            arb_valid_q, arb_valid_d;
  logic [IDW-1:0]  arb_id_q, arb_id_d;
  logic [OSW-1:0]  os_q, os_d;
  logic            idle_q, idle_d;

  logic [NREQ-1:0] wnz;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            slot_free;
  logic            os_ok;
  logic            grant;
  logic            reload;
  logic            hs;
  logic            done;
  logic [OSW:0]    os_sum;

  // Eligibility: requesting, non-zero weight, credit left in this round.
  always_comb begin
    wnz  = '0;
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      wnz[i]  = (rd_weight[i*WW +: WW] != '0);
      elig[i] = req_valid[i] && wnz[i] && (credit_q[i] != '0);
    end
  end

  nv_nvdla_cvif_rr_pick u_pick (
    .elig    (elig),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Grant gating: output slot free and the in-flight count (incl. the presented read) under the limit.
  always_comb begin
    slot_free = !arb_valid_q || arb_ready;
    os_sum    = {1'b0, os_q} + {{OSW{1'b0}}, arb_valid_q};
    os_ok     = os_sum < {1'b0, rd_os_cnt};
    grant     = slot_free && os_ok && pick_any;
    reload    = !pick_any && ((req_valid & wnz) != '0);
    req_ready = grant ? pick_oh : '0;
    hs        = arb_valid_q && arb_ready;
    done      = rsp_done && (os_q != '0);
  end

  // Next state: credits/pointer, output register, in-flight count and idle.
  always_comb begin
    credit_d = credit_q;
    ptr_d    = ptr_q;
    if (grant) begin
      credit_d[pick_idx] = credit_q[pick_idx] - 1'b1;
      if (credit_q[pick_idx] == WW'(1)) ptr_d = next_idx(pick_idx);
    end else if (reload) begin
      for (int i = 0; i < NREQ; i++) credit_d[i] = rd_weight[i*WW +: WW];
    end
    arb_valid_d = grant || (arb_valid_q && !arb_ready);
    arb_id_d    = grant ? pick_idx : arb_id_q;
    os_d        = os_q;
    if (hs && !done && (os_q != '1)) os_d = os_q + 1'b1;
    else if (!hs && done)            os_d = os_q - 1'b1;
    idle_d = (req_valid == '0) && !arb_valid_d && (os_d == '0);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < NREQ; i++) credit_q[i] <= '0;
      ptr_q       <= '0;
      arb_valid_q <= 1'b0;
      arb_id_q    <= '0;
      os_q        <= '0;
      idle_q      <= 1'b1;
    end else begin
      credit_q    <= credit_d;
      ptr_q       <= ptr_d;
      arb_valid_q <= arb_valid_d;
      arb_id_q    <= arb_id_d;
      os_q        <= os_d;
      idle_q      <= idle_d;
    end
  end

  assign arb_valid   = arb_valid_q;
  assign arb_id      = arb_id_q;
  assign os_inflight = os_q;
  assign idle        = idle_q;

`ifdef NVDLA_CVIF_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        os_stall;

  // Saturating count of cycles where only the outstanding limit held back a grant.
  always_comb begin
    os_stall = pick_any && slot_free && !os_ok;
    perf_d   = perf_q;
    if (perf_clr)                       perf_d = '0;
    else if (os_stall && perf_q != '1)  perf_d = perf_q + 1'b1;
  end

  // Perf counter register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) perf_q <= '0;
    else                  perf_q <= perf_d;
  end

  assign perf_os_stall = perf_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_cvif_rd_wrr_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
// Checks every cycle on the falling edge; inputs change 1 time unit after the rising edge.
// Summary line reports errors and total checks.
module tb_nv_nvdla_cvif_rd_wrr_arb;
  import nv_nvdla_cvif_arb_pkg::*;

  logic                nvdla_core_clk = 1'b0;
  logic                nvdla_core_rstn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*WW-1:0]  rd_weight;
  logic [OSW-1:0]      rd_os_cnt;
  logic                arb_valid;
  logic [IDW-1:0]      arb_id;
  logic                arb_ready;
  logic                rsp_done;
  logic [OSW-1:0]      os_inflight;
  logic                idle;
`ifdef NVDLA_CVIF_ARB_PERF_EN
  logic                perf_clr;
  logic [31:0]         perf_os_stall;
`endif

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  nv_nvdla_cvif_rd_wrr_arb dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .rd_weight       (rd_weight),
    .rd_os_cnt       (rd_os_cnt),
    .arb_valid       (arb_valid),
    .arb_id          (arb_id),
    .arb_ready       (arb_ready),
    .rsp_done        (rsp_done),
    .os_inflight     (os_inflight),
    .idle            (idle)
`ifdef NVDLA_CVIF_ARB_PERF_EN
    ,
    .perf_clr        (perf_clr),
    .perf_os_stall   (perf_os_stall)
`endif
  );

  int errs   = 0;
  int checks = 0;

  // Reference model state, expressed in plain integers.
  int  m_cred[NREQ];
  int  m_ptr;
  bit  m_av;
  int  m_aid;
  int  m_os;
  bit  m_idle;
  longint m_perf;
  int  hs_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wt(input int i);
    return int'(rd_weight[i*WW +: WW]);
  endfunction

  task automatic set_all_w(input int v);
    for (int i = 0; i < NREQ; i++) rd_weight[i*WW +: WW] = WW'(v);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREQ; i++) m_cred[i] = 0;
    m_ptr = 0; m_av = 0; m_aid = 0; m_os = 0; m_idle = 1; m_perf = 0;
  endtask

  // One clock: check DUT against the model on the falling edge, then advance the model.
  task automatic step();
    bit elig[NREQ];
    bit any_e, any_r, free, osok, g;
    int win;
    logic [NREQ-1:0] exp_rr;
    bit nav; int nos;
    @(negedge nvdla_core_clk);
    any_e = 0; any_r = 0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && wt(i) != 0 && m_cred[i] != 0;
      any_e |= elig[i];
      any_r |= req_valid[i] && wt(i) != 0;
    end
    free = !m_av || arb_ready;
    osok = (m_os + int'(m_av)) < int'(rd_os_cnt);
    g = 0; win = 0;
    if (free && osok) begin
      for (int k = 0; k < NREQ; k++) begin
        int j = (m_ptr + k) % NREQ;
        if (!g && elig[j]) begin g = 1; win = j; end
      end
    end
    exp_rr = '0;
    if (g) exp_rr[win] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    chk("arb_valid", 64'(arb_valid), 64'(m_av));
    if (m_av) chk("arb_id", 64'(arb_id), 64'(m_aid));
    chk("os_inflight", 64'(os_inflight), 64'(m_os));
    chk("idle", 64'(idle), 64'(m_idle));
`ifdef NVDLA_CVIF_ARB_PERF_EN
    chk("perf_os_stall", 64'(perf_os_stall), 64'(m_perf));
    if (perf_clr) m_perf = 0;
    else if (any_e && free && !osok && m_perf < 64'hffff_ffff) m_perf++;
`endif
    if (m_av && arb_ready) hs_log.push_back(m_aid);
    nos = m_os + ((m_av && arb_ready) ? 1 : 0) - ((rsp_done && m_os > 0) ? 1 : 0);
    nav = g || (m_av && !arb_ready);
    if (g) begin
      m_cred[win]--;
      if (m_cred[win] == 0) m_ptr = (win + 1) % NREQ;
      m_aid = win;
    end else if (!any_e && any_r) begin
      for (int i = 0; i < NREQ; i++) m_cred[i] = wt(i);
    end
    m_av = nav;
    m_os = nos;
    m_idle = (req_valid == '0) && !nav && (nos == 0);
    @(posedge nvdla_core_clk);
    #1;
  endtask

  // Assert reset (possibly mid-cycle), check its asynchronous effect, release after the next edge.
  task automatic do_reset();
    nvdla_core_rstn = 1'b0;
    #1;
    chk("rst_arb_valid", 64'(arb_valid), 64'd0);
    chk("rst_arb_id", 64'(arb_id), 64'd0);
    chk("rst_os_inflight", 64'(os_inflight), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
`ifdef NVDLA_CVIF_ARB_PERF_EN
    chk("rst_perf", 64'(perf_os_stall), 64'd0);
`endif
    @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;
    m_reset();
  endtask

  task automatic tied_step();
    rsp_done = m_av && arb_ready && (m_os > 0);
    step();
  endtask

  initial begin
    int exp_seq[$];
    int hs_cnt;
    int held_id;
    nvdla_core_rstn = 1'b1;
    req_valid = '0; arb_ready = 1'b0; rsp_done = 1'b0;
    rd_os_cnt = 8'hff; rd_weight = '0;
`ifdef NVDLA_CVIF_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    m_reset();
    #2;
    do_reset();

    // 1: all weights 1, everyone requesting, completions tied to handshakes.
    set_all_w(1); rd_os_cnt = 8'hff; req_valid = '1; arb_ready = 1'b1;
    hs_log.delete();
    for (int c = 0; c < 30; c++) tied_step();
    exp_seq = '{0,1,2,3,4,5,6,7,8,9,10,11,0};
    for (int i = 0; i < exp_seq.size(); i++)
      chk($sformatf("t1_seq[%0d]", i), 64'(hs_log[i]), 64'(exp_seq[i]));

    // 6a: reset in the middle of the burst.
    chk("t6_burst_active", 64'(arb_valid), 64'd1);
    #2;
    do_reset();
    rsp_done = 1'b0;

    // 2: bdma=3, sdp=1, all others masked.
    rd_weight = '0;
    rd_weight[CLI_BDMA*WW +: WW] = 8'd3;
    rd_weight[CLI_SDP*WW +: WW]  = 8'd1;
    hs_log.delete();
    for (int c = 0; c < 20; c++) tied_step();
    exp_seq = '{0,0,0,1,0,0,0,1};
    for (int i = 0; i < exp_seq.size(); i++)
      chk($sformatf("t2_seq[%0d]", i), 64'(hs_log[i]), 64'(exp_seq[i]));

    // 4: downstream stalls for 5 cycles; id must hold.
    rsp_done = 1'b0;
    arb_ready = 1'b0;
    held_id = int'(arb_id);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_id_hold", 64'(arb_id), 64'(held_id));
    end
    arb_ready = 1'b1;
    for (int c = 0; c < 4; c++) tied_step();

    // 3: outstanding limit of 2 with no completions.
    do_reset();
    set_all_w(1); rd_os_cnt = 8'd2; rsp_done = 1'b0;
    hs_log.delete();
    for (int c = 0; c < 10; c++) step();
    hs_cnt = hs_log.size();
    chk("t3_handshakes", 64'(hs_cnt), 64'd2);
    chk("t3_os", 64'(os_inflight), 64'd2);
    chk("t3_arb_valid", 64'(arb_valid), 64'd0);
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    step();
    chk("t3_regrant", 64'(arb_valid), 64'd1);

    // 5: handshake and completion together at os_inflight=1.
    chk("t5_pre_os", 64'(os_inflight), 64'd1);
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    chk("t5_os_hold", 64'(os_inflight), 64'd1);
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      rsp_done = (m_os > 0); step();
    end
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    chk("t5_os_zero", 64'(os_inflight), 64'd0);
    step();
    chk("t5_idle", 64'(idle), 64'd1);

`ifdef NVDLA_CVIF_ARB_PERF_EN
    // 6b: limit of 0 blocks every grant; count exactly 10 stalled cycles.
    do_reset();
    set_all_w(1); rd_os_cnt = 8'd0; req_valid = '1;
    step();
    perf_clr = 1'b1; step(); perf_clr = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("t6_perf", 64'(perf_os_stall), 64'd10);
`endif

    // Random traffic.
    do_reset();
    for (int i = 0; i < NREQ; i++) rd_weight[i*WW +: WW] = WW'($urandom_range(0, 3));
    rd_os_cnt = 8'd3;
    for (int c = 0; c < 600; c++) begin
      req_valid = NREQ'($urandom);
      arb_ready = ($urandom_range(0, 3) != 0);
      rsp_done  = (m_os > 0) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) rd_os_cnt = OSW'($urandom_range(0, 5));
      if ($urandom_range(0, 79) == 0)
        rd_weight[$urandom_range(0, NREQ-1)*WW +: WW] = WW'($urandom_range(0, 4));
`ifdef NVDLA_CVIF_ARB_PERF_EN
      perf_clr = ($urandom_range(0, 99) == 0);
`endif
      step();
      if (c == 300) begin #2; do_reset(); end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
